// File: rtl/uart_tx_if.sv
// UART transmit request/status bundle: parallel word and frame format in, serial line and status out.
// The master side drives a request; the slave side serialises it.
interface uart_tx_if #(
    parameter int DIV_W = 16
);
    logic             start;
    logic [7:0]       data_in;
    logic [DIV_W-1:0] br_div;
    logic             word;
    logic             stop;
    logic             parity_en;
    logic             parity_odd;
    logic             tx_out;
    logic             busy;
    logic             finish;

    modport master (
        output start, data_in, br_div, word, stop, parity_en, parity_odd,
        input  tx_out, busy, finish
    );

    modport slave (
        input  start, data_in, br_div, word, stop, parity_en, parity_odd,
        output tx_out, busy, finish
    );
endinterface

// File: rtl/uart_tx.sv
// UART serialiser: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits; tx_out is registered.
// A frame takes br_div*(1+W+P+S) clocks; start is ignored while busy, so there is no queueing.
module uart_tx #(
    parameter int DIV_W = 16
) (
    input  logic    clk,
    input  logic    rst,
    uart_tx_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q,   state_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             finish_q,  finish_d;
    logic [DIV_W-1:0] baud_q,    baud_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [2:0]       d_count_q, d_count_d;
    logic             s_count_q, s_count_d;
    logic [7:0]       shreg_q,   shreg_d;
    logic             word_q,    word_d;
    logic             stop_q,    stop_d;
    logic             par_en_q,  par_en_d;
    logic             par_bit_q, par_bit_d;

    logic accept;
    logic bit_end;
    logic last_data;

    assign accept    = bus.start && !busy_q;
    assign bit_end   = (baud_q == (div_q - DIV_ONE));
    assign last_data = (d_count_q == (word_q ? 3'd7 : 3'd6));

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        finish_d  = 1'b0;
        baud_d    = baud_q;
        div_d     = div_q;
        d_count_d = d_count_q;
        s_count_d = s_count_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        stop_d    = stop_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d   = S_START;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
                baud_d    = '0;
                div_d     = (bus.br_div == '0) ? DIV_ONE : bus.br_div;
                shreg_d   = bus.data_in;
                word_d    = bus.word;
                stop_d    = bus.stop;
                par_en_d  = bus.parity_en;
                // bit 7 must not leak into parity on 7-bit words
                par_bit_d = (^{bus.word & bus.data_in[7], bus.data_in[6:0]}) ^ bus.parity_odd;
            end
        end else begin
            baud_d = bit_end ? '0 : (baud_q + DIV_ONE);
            if (bit_end) begin
                unique case (state_q)
                    S_START: begin
                        state_d   = S_DATA;
                        d_count_d = 3'd0;
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                    S_DATA: begin
                        if (last_data) begin
                            s_count_d = 1'b0;
                            if (par_en_q) begin
                                state_d = S_PARITY;
                                tx_d    = par_bit_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            d_count_d = d_count_q + 3'd1;
                            tx_d      = shreg_q[0];
                            shreg_d   = {1'b0, shreg_q[7:1]};
                        end
                    end
                    S_PARITY: begin
                        state_d   = S_STOP;
                        s_count_d = 1'b0;
                        tx_d      = 1'b1;
                    end
                    S_STOP: begin
                        tx_d = 1'b1;
                        if (stop_q && !s_count_q) begin
                            s_count_d = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            busy_d   = 1'b0;
                            finish_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            baud_q    <= '0;
            div_q     <= DIV_ONE;
            d_count_q <= 3'd0;
            s_count_q <= 1'b0;
            shreg_q   <= 8'h00;
            word_q    <= 1'b1;
            stop_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            d_count_q <= d_count_d;
            s_count_q <= s_count_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            stop_q    <= stop_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
    assign bus.finish = finish_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued per frame and checked every clock.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.DIV_W(16)) bus ();
    uart_tx #(.DIV_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input bit w, input bit st,
                               input bit pe, input bit po);
        int nb;
        bit p;
        nb = w ? 8 : 7;
        p  = po;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
        if (pe) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (st) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] div, input bit w, input bit st,
                        input bit pe, input bit po, input bit hold);
        @(negedge clk);
        bus.data_in    = d;
        bus.br_div     = div;
        bus.word       = w;
        bus.stop       = st;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.start      = 1'b1;
        build_frame(d, w, st, pe, po);
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Checks every clock of the queued frame, then the finish cycle.
    task automatic check_frame(input int div, input string tag, input int inject);
        int   eff;
        int   cyc;
        logic b;
        eff = (div == 0) ? 1 : div;
        cyc = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int k = 0; k < eff; k++) begin
                @(negedge clk);
                cyc++;
                chk({tag, "_tx"}, bus.tx_out, b);
                chk({tag, "_busy"}, bus.busy, 1'b1);
                chk({tag, "_fin0"}, bus.finish, 1'b0);
                if (cyc == inject) begin
                    bus.start     = 1'b1;
                    bus.data_in   = 8'hFF;
                    bus.br_div    = 16'd7;
                    bus.word      = 1'b0;
                    bus.parity_en = 1'b1;
                end else if (cyc == inject + 1) begin
                    bus.start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk({tag, "_fin"}, bus.finish, 1'b1);
        chk({tag, "_endbusy"}, bus.busy, 1'b0);
        chk({tag, "_endtx"}, bus.tx_out, 1'b1);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_idlefin"}, bus.finish, 1'b0);
        chk({tag, "_idlebusy"}, bus.busy, 1'b0);
        chk({tag, "_idletx"}, bus.tx_out, 1'b1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.data_in    = 8'h00;
        bus.br_div     = 16'd1;
        bus.word       = 1'b1;
        bus.stop       = 1'b0;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", bus.tx_out, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_fin", bus.finish, 1'b0);
        rst = 1'b0;

        // 8N1 0xA5 at 4 clocks/bit
        send(8'hA5, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame(4, "t1", -5);
        idle_chk("t1");

        // 7E2 0x55 at 3 clocks/bit; 0xD5 must give the same frame
        send(8'h55, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame(3, "t2", -5);
        idle_chk("t2");
        send(8'hD5, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame(3, "t2b", -5);
        idle_chk("t2b");

        // 8O1 parity on 0x00 and 0x01
        send(8'h00, 16'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame(2, "t3a", -5);
        idle_chk("t3a");
        send(8'h01, 16'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame(2, "t3b", -5);
        idle_chk("t3b");

        // mid-frame start with altered inputs is ignored
        send(8'h3C, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame(4, "t4", 10);
        idle_chk("t4");

        // start held through finish: second frame after one idle clock
        send(8'h5A, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_frame(2, "t4a", -5);
        bus.data_in = 8'hC3;
        build_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_frame(2, "t4b", -5);
        idle_chk("t4b");

        // reset during data bit 3 of 0xA5
        send(8'hA5, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        repeat (18) @(negedge clk);
        chk("t5_bit3", bus.tx_out, 1'b0);
        chk("t5_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rsttx", bus.tx_out, 1'b1);
        chk("t5_rstbusy", bus.busy, 1'b0);
        chk("t5_rstfin", bus.finish, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_chk("t5");
        send(8'h96, 16'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame(3, "t5n", -5);
        idle_chk("t5n");

        // divisor 0 and 1 both give one clock per bit
        send(8'h81, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame(0, "t6a", -5);
        idle_chk("t6a");
        send(8'h81, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame(1, "t6b", -5);
        idle_chk("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
